// File: rtl/dispatch_sched_8ch.sv
// dispatch_sched_8ch: in-order write queue dispatching to 8 channels with head-of-line timeout
module dispatch_sched_8ch #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [15:0]              in_data,
    input  logic [2:0]               in_dest,
    input  logic [7:0]               dst_ready,
    output logic [2:0]               out_sel,
    output logic [15:0]              out_data,
    output logic [7:0]               out_we,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     busy,
    output logic                     err_timeout,
    input  logic                     clr_err
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
    localparam logic [7:0] TLIM = 8'(TIMEOUT - 1);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    logic [18:0]   r_mem [DEPTH];
    logic [AW-1:0] r_rd;
    logic [AW-1:0] r_wr;
    logic [AW:0]   r_count;
    logic [7:0]    r_tcnt;
    logic [18:0]   w_head;
    logic [1:0]    w_state;
    logic          w_send;
    logic          w_drop;
    logic          w_push;
    logic          w_pop;

    assign w_head     = r_mem[r_rd];
    assign in_ready   = r_count < FULL;
    assign fifo_count = r_count;
    assign busy       = (r_count != '0) || (out_we != 8'd0);

    // State derived each cycle from registered occupancy and the live ready of the head's channel
    always_comb begin
        w_state = (r_count == '0) ? S_IDLE : (dst_ready[w_head[2:0]] ? S_SEND : S_WAIT);
        w_send  = w_state == S_SEND;
        w_drop  = (w_state == S_WAIT) && (r_tcnt == TLIM);
        w_push  = in_valid && in_ready;
        w_pop   = w_send || w_drop;
    end

    // Queue storage; payload needs no reset because occupancy guards every read
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= {in_data, in_dest};
    end

    // Pointers, occupancy, blocked-cycle counter and sticky timeout flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd        <= '0;
            r_wr        <= '0;
            r_count     <= '0;
            r_tcnt      <= 8'd0;
            err_timeout <= 1'b0;
        end else begin
            r_rd        <= w_pop ? r_rd + 1'b1 : r_rd;
            r_wr        <= w_push ? r_wr + 1'b1 : r_wr;
            r_count     <= r_count + (AW + 1)'(w_push) - (AW + 1)'(w_pop);
            r_tcnt      <= (w_state == S_WAIT && !w_drop) ? r_tcnt + 8'd1 : 8'd0;
            err_timeout <= w_drop ? 1'b1 : (clr_err ? 1'b0 : err_timeout);
        end
    end

    // Registered demux drive: one-cycle strobe per dispatched entry, select/data hold otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_we   <= 8'd0;
            out_sel  <= 3'd0;
            out_data <= 16'd0;
        end else begin
            out_we   <= w_send ? 8'd1 << w_head[2:0] : 8'd0;
            out_sel  <= w_send ? w_head[2:0] : out_sel;
            out_data <= w_send ? w_head[18:3] : out_data;
        end
    end
endmodule
